mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  single system clock, all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [31:26] from instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from instruction register.
REQ-006 zero  input  1  ALU zero flag, combinational, same cycle.
REQ-007 alucontrol  output  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-008 alusrca  output  1  0 = PC, 1 = register A.
REQ-009 alusrcb  output  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-011 pcen, irwrite, memwrite, regwrite  output  1 each  write strobes.
REQ-012 iord, regdst, memtoreg  output  1 each  mux selects.
REQ-013 illegal  output  1  one-cycle pulse on unsupported opcode or funct.

Function
REQ-014 Moore FSM: registered state, outputs decoded from state only; pcen is the sole exception (uses zero).
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-016 Defaults in every state: all strobes 0, all selects 0, alucontrol 0010.
REQ-017 FETCH: irwrite=1, pcen=1, alusrcb=01, ADD; next DECODE.
REQ-018 DECODE: alusrcb=11, ADD; next by opcode: 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 001000 -> ADDIEX, 000010 -> JEX, other -> FETCH with illegal=1.
REQ-019 MEMADR: alusrca=1, alusrcb=10, ADD; next MEMRD if lw, MEMWR if sw.
REQ-020 MEMRD: iord=1; next MEMWB. MEMWB: regwrite=1, memtoreg=1; next FETCH.
REQ-021 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-022 RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR; next RTYPEWB.
REQ-023 Unsupported funct in RTYPEEX: alucontrol=0010, illegal=1, next FETCH (no writeback).
REQ-024 RTYPEWB: regwrite=1, regdst=1; next FETCH.
REQ-025 BEQEX: alusrca=1, alusrcb=00, SUB, pcsrc=01, pcen=zero; next FETCH.
REQ-026 ADDIEX: alusrca=1, alusrcb=10, ADD; next ADDIWB. ADDIWB: regwrite=1; next FETCH.
REQ-027 JEX: pcsrc=10, pcen=1; next FETCH.
REQ-028 Latencies in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-029 opcode/funct sampled only in DECODE/MEMADR/RTYPEEX; changes elsewhere ignored.

Reset
REQ-030 reset high at an edge: state <= FETCH, regardless of current state (mid-instruction abort).
REQ-031 While reset is high all strobes (pcen, irwrite, memwrite, regwrite) and illegal SHALL be 0; selects at defaults.
REQ-032 First FETCH strobes appear in the first cycle after reset deasserts.

Structure
REQ-033 Shared package holds state encoding, 4-bit ALU control codes, opcode and funct constants; ALU and this block use the same code constants.
REQ-034 One sub-module alu_decoder: combinational funct -> alucontrol plus illegal-funct flag.

Verification
REQ-035 lw (opcode 100011) after reset -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-036 R-type funct 100010 -> alucontrol=0110 in cycle 3, regwrite=1 and regdst=1 in cycle 4.
REQ-037 beq with zero=1 -> pcen=1, pcsrc=01 in cycle 3; repeat with zero=0 -> pcen=0.
REQ-038 opcode 111111 -> illegal=1 in DECODE, next state FETCH, no write strobe.
REQ-039 R-type funct 000000 -> illegal=1 in RTYPEEX, regwrite never asserted.
REQ-040 reset asserted in MEMWR of sw -> memwrite=0 that cycle, FETCH after reset release.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared definitions for the multicycle controller: state encoding, ALU control
// codes, opcode/funct constants and the control-word payload.
package mc_control_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALUC_W  = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTYPEEX,
    RTYPEWB,
    BEQEX,
    ADDIEX,
    ADDIWB,
    JEX
  } state_e;

  // ALU operation codes, shared with the ALU itself
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

  localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [ALUC_W-1:0] alucontrol;
    logic              alusrca;
    logic [SEL_W-1:0]  alusrcb;
    logic [SEL_W-1:0]  pcsrc;
    logic              pcen;
    logic              irwrite;
    logic              memwrite;
    logic              regwrite;
    logic              iord;
    logic              regdst;
    logic              memtoreg;
    logic              illegal;
  } ctrl_t;

  // Idle control word: no strobes, all selects zero, ALU adding
  function automatic ctrl_t ctrl_default();
    ctrl_t c;
    c            = '0;
    c.alucontrol = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// control strobes and mux selects out.
interface mc_control_if import mc_control_pkg::*; ();

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               zero;
  logic [ALUC_W-1:0]  alucontrol;
  logic               alusrca;
  logic [SEL_W-1:0]   alusrcb;
  logic [SEL_W-1:0]   pcsrc;
  logic               pcen;
  logic               irwrite;
  logic               memwrite;
  logic               regwrite;
  logic               iord;
  logic               regdst;
  logic               memtoreg;
  logic               illegal;

  modport master (
    input  opcode, funct, zero,
    output alucontrol, alusrca, alusrcb, pcsrc, pcen, irwrite, memwrite,
           regwrite, iord, regdst, memtoreg, illegal
  );

  modport slave (
    output opcode, funct, zero,
    input  alucontrol, alusrca, alusrcb, pcsrc, pcen, irwrite, memwrite,
           regwrite, iord, regdst, memtoreg, illegal
  );

endinterface

// File: rtl/mc_control_alu_decoder.sv
// R-type funct field to ALU operation, flagging functs the datapath cannot execute.
module alu_decoder import mc_control_pkg::*; (
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [ALUC_W-1:0]  alucontrol_c_o,
  output logic               funct_illegal_c_o
);

  always_comb begin
    alucontrol_c_o    = ALU_ADD;
    funct_illegal_c_o = 1'b0;
    case (funct_i)
      FN_ADD:  alucontrol_c_o = ALU_ADD;
      FN_SUB:  alucontrol_c_o = ALU_SUB;
      FN_AND:  alucontrol_c_o = ALU_AND;
      FN_OR:   alucontrol_c_o = ALU_OR;
      FN_SLT:  alucontrol_c_o = ALU_SLT;
      FN_NOR:  alucontrol_c_o = ALU_NOR;
      default: funct_illegal_c_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset controller: Moore FSM whose control word is decoded
// from the current state; only pcen (branch) also looks at the ALU zero flag.
module mc_control import mc_control_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  state_e            state_q;
  state_e            state_d;
  ctrl_t             ctrl_c;
  logic [ALUC_W-1:0] rtype_aluc_c;
  logic              funct_bad_c;

  alu_decoder u_alu_decoder (
    .funct_i          (bus.funct),
    .alucontrol_c_o   (rtype_aluc_c),
    .funct_illegal_c_o(funct_bad_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = ctrl_default();
    case (state_q)
      FETCH: begin
        ctrl_c.irwrite = 1'b1;
        ctrl_c.pcen    = 1'b1;
        ctrl_c.alusrcb = SRCB_FOUR;
        state_d        = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here in case this turns out to be a beq
        ctrl_c.alusrcb = SRCB_IMMSH;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default: begin
            ctrl_c.illegal = 1'b1;
            state_d        = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = SRCB_IMM;
        state_d        = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl_c.iord = 1'b1;
        state_d     = MEMWB;
      end
      MEMWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memtoreg = 1'b1;
        state_d         = FETCH;
      end
      MEMWR: begin
        ctrl_c.iord     = 1'b1;
        ctrl_c.memwrite = 1'b1;
        state_d         = FETCH;
      end
      RTYPEEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = SRCB_REGB;
        if (funct_bad_c) begin
          ctrl_c.illegal = 1'b1;
          state_d        = FETCH;
        end else begin
          ctrl_c.alucontrol = rtype_aluc_c;
          state_d           = RTYPEWB;
        end
      end
      RTYPEWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.regdst   = 1'b1;
        state_d         = FETCH;
      end
      BEQEX: begin
        ctrl_c.alusrca    = 1'b1;
        ctrl_c.alusrcb    = SRCB_REGB;
        ctrl_c.alucontrol = ALU_SUB;
        ctrl_c.pcsrc      = PCSRC_ALUOUT;
        ctrl_c.pcen       = bus.zero;
        state_d           = FETCH;
      end
      ADDIEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = SRCB_IMM;
        state_d        = ADDIWB;
      end
      ADDIWB: begin
        ctrl_c.regwrite = 1'b1;
        state_d         = FETCH;
      end
      JEX: begin
        ctrl_c.pcsrc = PCSRC_JUMP;
        ctrl_c.pcen  = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Reset may land mid-instruction; suppress any strobe of the aborted state
    if (reset) ctrl_c = ctrl_default();
  end

  assign bus.alucontrol = ctrl_c.alucontrol;
  assign bus.alusrca    = ctrl_c.alusrca;
  assign bus.alusrcb    = ctrl_c.alusrcb;
  assign bus.pcsrc      = ctrl_c.pcsrc;
  assign bus.pcen       = ctrl_c.pcen;
  assign bus.irwrite    = ctrl_c.irwrite;
  assign bus.memwrite   = ctrl_c.memwrite;
  assign bus.regwrite   = ctrl_c.regwrite;
  assign bus.iord       = ctrl_c.iord;
  assign bus.regdst     = ctrl_c.regdst;
  assign bus.memtoreg   = ctrl_c.memtoreg;
  assign bus.illegal    = ctrl_c.illegal;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction expected control sequences built from
// the instruction-level behaviour, compared cycle by cycle.
module tb_mc_control;

  typedef struct packed {
    logic [3:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       illegal;
  } exp_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t        exp_q[$];
  logic [5:0]  fn_tab[6]   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
  logic [3:0]  aluc_tab[6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

  mc_control_if bus ();

  mc_control dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t idle();
    exp_t e;
    e            = '0;
    e.alucontrol = 4'b0010;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t e;
    e.alucontrol = bus.alucontrol;
    e.alusrca    = bus.alusrca;
    e.alusrcb    = bus.alusrcb;
    e.pcsrc      = bus.pcsrc;
    e.pcen       = bus.pcen;
    e.irwrite    = bus.irwrite;
    e.memwrite   = bus.memwrite;
    e.regwrite   = bus.regwrite;
    e.iord       = bus.iord;
    e.regdst     = bus.regdst;
    e.memtoreg   = bus.memtoreg;
    e.illegal    = bus.illegal;
    return e;
  endfunction

  // Reference: the full cycle-by-cycle control sequence of one instruction
  function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    exp_t c;
    int   hit;
    exp_q.delete();
    c = idle(); c.irwrite = 1'b1; c.pcen = 1'b1; c.alusrcb = 2'b01;
    exp_q.push_back(c);
    c = idle(); c.alusrcb = 2'b11;
    c.illegal = !(op inside {LW, SW, RT, BEQ, ADDI, JMP});
    exp_q.push_back(c);
    if (op == LW || op == SW) begin
      c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'b10; exp_q.push_back(c);
      c = idle(); c.iord = 1'b1; c.memwrite = (op == SW); exp_q.push_back(c);
      if (op == LW) begin
        c = idle(); c.regwrite = 1'b1; c.memtoreg = 1'b1; exp_q.push_back(c);
      end
    end else if (op == RT) begin
      hit = -1;
      foreach (fn_tab[i]) if (fn_tab[i] == fn) hit = i;
      c = idle(); c.alusrca = 1'b1;
      if (hit < 0) begin
        c.illegal = 1'b1;
        exp_q.push_back(c);
      end else begin
        c.alucontrol = aluc_tab[hit];
        exp_q.push_back(c);
        c = idle(); c.regwrite = 1'b1; c.regdst = 1'b1; exp_q.push_back(c);
      end
    end else if (op == BEQ) begin
      c = idle(); c.alusrca = 1'b1; c.alucontrol = 4'b0110; c.pcsrc = 2'b01; c.pcen = z;
      exp_q.push_back(c);
    end else if (op == ADDI) begin
      c = idle(); c.alusrca = 1'b1; c.alusrcb = 2'b10; exp_q.push_back(c);
      c = idle(); c.regwrite = 1'b1; exp_q.push_back(c);
    end else if (op == JMP) begin
      c = idle(); c.pcsrc = 2'b10; c.pcen = 1'b1; exp_q.push_back(c);
    end
  endfunction

  // Drive cycle k of an instruction; fields not looked at may be scrambled
  task automatic drive_cycle(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int k, input bit scramble);
    if (scramble && (k == 0 || k >= 3)) begin
      bus.opcode = 6'($urandom);
      bus.funct  = 6'($urandom);
    end else begin
      bus.opcode = op;
      bus.funct  = fn;
    end
    bus.zero = (scramble && k != 2) ? 1'($urandom) : z;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.opcode = SW;
    bus.funct  = 6'($urandom);
    bus.zero   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (sample() !== idle()) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: got %h expected %h", i, sample(), idle());
      end
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_lw();
    model_instr(LW, 6'h00, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      drive_cycle(LW, 6'h00, 1'b0, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_rtype_sub();
    model_instr(RT, 6'b100010, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      drive_cycle(RT, 6'b100010, 1'b0, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL rtype_sub cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_beq(input logic z);
    model_instr(BEQ, 6'h15, z);
    for (int k = 0; k < exp_q.size(); k++) begin
      drive_cycle(BEQ, 6'h15, z, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL beq_z%0b cyc%0d: got %h expected %h", z, k, sample(), exp_q[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal_opcode();
    model_instr(6'b111111, 6'h00, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      drive_cycle(6'b111111, 6'h00, 1'b0, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL illegal_op cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_illegal_funct();
    model_instr(RT, 6'b000000, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      drive_cycle(RT, 6'b000000, 1'b0, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL illegal_funct cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_abort();
    model_instr(SW, 6'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(SW, 6'h00, 1'b0, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL abort_sw cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
      end
      next_cycle();
    end
    reset = 1'b1;
    drive_cycle(SW, 6'h00, 1'b0, 3, 1'b0);
    checks++;
    if (bus.memwrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_memwrite: got %b expected 0", bus.memwrite);
    end
    checks++;
    if (sample() !== idle()) begin
      errors++;
      $display("FAIL abort_idle: got %h expected %h", sample(), idle());
    end
    next_cycle();
    reset = 1'b0;
    model_instr(JMP, 6'h00, 1'b0);
    for (int k = 0; k < exp_q.size(); k++) begin
      drive_cycle(JMP, 6'h00, 1'b0, k, 1'b0);
      checks++;
      if (sample() !== exp_q[k]) begin
        errors++;
        $display("FAIL abort_restart cyc%0d: got %h expected %h", k, sample(), exp_q[k]);
      end
      next_cycle();
    end
  endtask

  // Random back-to-back instruction stream with unsampled fields scrambled
  task automatic test_random(input int n);
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    for (int i = 0; i < n; i++) begin
      fn = fn_tab[$urandom_range(0, 5)];
      z  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = ADDI;
        5: op = JMP;
        6: op = 6'($urandom);
        default: begin op = RT; fn = 6'($urandom); end
      endcase
      model_instr(op, fn, z);
      for (int k = 0; k < exp_q.size(); k++) begin
        drive_cycle(op, fn, z, k, 1'b1);
        checks++;
        if (sample() !== exp_q[k]) begin
          errors++;
          $display("FAIL random i%0d op=%b fn=%b cyc%0d: got %h expected %h",
                   i, op, fn, k, sample(), exp_q[k]);
        end
        next_cycle();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_sub();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal_opcode();
    test_illegal_funct();
    test_lw();
    test_reset_abort();
    test_random(150);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
